// File: rtl/ring_counter_16bit.sv
// Phase accumulator at the front of the sine generator: each clock adds a programmable
// step to the running phase modulo 2^WIDTH and flags the cycle after an overflow.
module ring_counter_16bit #(
  parameter int unsigned          WIDTH       = 16,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             SCLR,
  input  logic [WIDTH-1:0] increment_value,
  output logic [WIDTH-1:0] count_out,
  output logic             wrap
);

  logic [WIDTH-1:0] r_acc;
  logic             r_wrap;
  logic [WIDTH:0]   w_sum;

  // One extra bit so the carry out of the add becomes the wrap flag.
  assign w_sum = {1'b0, r_acc} + {1'b0, increment_value};

  always_ff @(posedge CLK or negedge SCLR) begin
    if (!SCLR) begin
      r_acc  <= RESET_VALUE;
      r_wrap <= 1'b0;
    end else begin
      r_acc  <= w_sum[WIDTH-1:0];
      r_wrap <= w_sum[WIDTH];
    end
  end

  assign count_out = r_acc;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_ring_counter_16bit.sv
// Directed and randomized checks of the phase accumulator against an arithmetic model
// of modulo-65536 accumulation with an overflow flag.
module tb_ring_counter_16bit;

  logic        CLK;
  logic        SCLR;
  logic [15:0] increment_value;
  logic [15:0] count_out;
  logic        wrap;

  int tests_run;
  int tests_failed;

  // Reference model: phase as a plain integer, wrap = sum reached 2^16.
  int unsigned mdl_phase;
  logic        mdl_wrap;

  ring_counter_16bit #(.WIDTH(16), .RESET_VALUE(16'd0)) dut (
    .CLK             (CLK),
    .SCLR            (SCLR),
    .increment_value (increment_value),
    .count_out       (count_out),
    .wrap            (wrap)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag);
    tests_run++;
    assert (count_out === mdl_phase[15:0]) else begin
      tests_failed++;
      $error("FAIL %s count_out got %0d expected %0d", tag, count_out, mdl_phase[15:0]);
    end
    tests_run++;
    assert (wrap === mdl_wrap) else begin
      tests_failed++;
      $error("FAIL %s wrap got %0b expected %0b", tag, wrap, mdl_wrap);
    end
  endtask

  // Called shortly after a rising edge; applies inc, clocks once, checks.
  task automatic step(input logic [15:0] inc, input string tag);
    int unsigned s;
    increment_value = inc;
    @(posedge CLK);
    s = mdl_phase + 32'(inc);
    mdl_wrap  = (s >= 32'd65536);
    mdl_phase = s % 32'd65536;
    #1;
    chk(tag);
  endtask

  task automatic model_reset();
    mdl_phase = 0;
    mdl_wrap  = 1'b0;
  endtask

  // Entered shortly after a rising edge; pulses reset between edges, spanning one edge.
  task automatic reset_pulse(input string tag);
    #3;
    SCLR = 1'b0;
    model_reset();
    #1;
    chk({tag, "_async"});
    @(posedge CLK);
    #1;
    chk({tag, "_hold"});
    #2;
    SCLR = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_reset();
    SCLR            = 1'b0;
    increment_value = 'x;

    // Reset held across clock edges with an unknown step on the input.
    #2;
    chk("reset_t2");
    repeat (2) begin
      @(posedge CLK);
      #1;
      chk("reset_edge");
    end

    SCLR = 1'b1;
    for (int i = 1; i <= 163; i++) step(16'd400, "ramp400");
    tests_run++;
    assert (count_out === 16'd65200) else begin
      tests_failed++;
      $error("FAIL after163 count_out got %0d expected 65200", count_out);
    end
    step(16'd400, "wrap164");
    tests_run++;
    assert (count_out === 16'd64 && wrap === 1'b1) else begin
      tests_failed++;
      $error("FAIL add164 got %0d/%0b expected 64/1", count_out, wrap);
    end
    step(16'd400, "after_wrap");
    tests_run++;
    assert (count_out === 16'd464 && wrap === 1'b0) else begin
      tests_failed++;
      $error("FAIL add165 got %0d/%0b expected 464/0", count_out, wrap);
    end

    for (int i = 0; i < 4; i++) step(16'd0, "inc_zero");
    for (int i = 0; i < 6; i++) step(16'hFFFF, "inc_ffff");

    // From reset, 0 + 0xFFFF is the one all-ones step that does not carry.
    reset_pulse("rst_a");
    step(16'hFFFF, "ffff_from0");
    step(16'hFFFF, "ffff_next");

    // Asynchronous clear while the phase sits at 0x1234.
    reset_pulse("rst_b");
    step(16'h1234, "load1234");
    reset_pulse("rst_1234");
    step(16'h0ABC, "first_after_rst");

    reset_pulse("rst_c");
    for (int i = 0; i < 8; i++) step(16'h4000, "period4");

    // Random steps with occasional mid-run resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) reset_pulse("rst_rand");
      case ($urandom_range(0, 3))
        0:       step(16'($urandom_range(0, 3)), "rand_small");
        1:       step(16'hFFFF - 16'($urandom_range(0, 3)), "rand_big");
        default: step(16'($urandom), "rand_any");
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
